// File: rtl/ex_muldiv.sv
// Iterative radix-2 RV32M multiply/divide unit sitting beside the EX-stage ALU.
// Holds the pipeline via stall while a shift-add or restoring-divide sequence runs.
module ex_muldiv #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic            flush,
  output logic            stall,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN);
  localparam logic [CW-1:0] CLAST = CW'(XLEN - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]        state;
  logic [CW-1:0]     count;
  logic [2:0]        op_q;
  logic              neg_a_q, neg_b_q;
  logic [XLEN-1:0]   m;        // multiplicand (MUL*) or divisor (DIV*/REM*) magnitude
  logic [2*XLEN-1:0] p;        // {acc, multiplier} or {remainder, quotient}

  logic              sgn_a, sgn_b, neg_a, neg_b, is_div, special;
  logic [XLEN-1:0]   abs_a, abs_b, spec_val;
  logic [XLEN:0]     msum, dshr;
  logic [XLEN+1:0]   ddiff;
  logic [2*XLEN-1:0] mul_nxt, div_nxt, prod;
  logic [XLEN-1:0]   quo, rem, fix_val;
  logic              capture;
  logic              unused_bits;

  always_comb begin
    sgn_a   = (op != 3'd3) && (op != 3'd5) && (op != 3'd7);
    sgn_b   = sgn_a && (op != 3'd2);
    neg_a   = sgn_a & rs1[XLEN-1];
    neg_b   = sgn_b & rs2[XLEN-1];
    abs_a   = neg_a ? -rs1 : rs1;
    abs_b   = neg_b ? -rs2 : rs2;
    is_div  = op[2];
    special = 1'b0;
    spec_val = '0;
    if (is_div && rs2 == '0) begin
      special  = 1'b1;
      spec_val = op[1] ? rs1 : '1;
    end else if (is_div && !op[0] && rs1 == {1'b1, {(XLEN-1){1'b0}}} && rs2 == '1) begin
      // signed overflow: quotient wraps to the dividend, remainder is zero
      special  = 1'b1;
      spec_val = op[1] ? '0 : rs1;
    end
  end

  assign capture = (state == S_IDLE) && start && !flush;

  always_comb begin
    msum    = {1'b0, p[2*XLEN-1:XLEN]} + (p[0] ? {1'b0, m} : '0);
    mul_nxt = {msum, p[XLEN-1:1]};
    dshr    = p[2*XLEN-1:XLEN-1];
    ddiff   = {1'b0, dshr} - {2'b0, m};
    div_nxt = ddiff[XLEN+1] ? {dshr[XLEN-1:0], p[XLEN-2:0], 1'b0}
                            : {ddiff[XLEN-1:0], p[XLEN-2:0], 1'b1};
    prod    = (neg_a_q ^ neg_b_q) ? -p : p;
    quo     = (neg_a_q ^ neg_b_q) ? -p[XLEN-1:0] : p[XLEN-1:0];
    rem     = neg_a_q ? -p[2*XLEN-1:XLEN] : p[2*XLEN-1:XLEN];
    case (op_q)
      3'd0:       fix_val = prod[XLEN-1:0];
      3'd1, 3'd2,
      3'd3:       fix_val = prod[2*XLEN-1:XLEN];
      3'd4, 3'd5: fix_val = quo;
      default:    fix_val = rem;
    endcase
  end

  assign unused_bits = ^{dshr[XLEN], ddiff[XLEN]};

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= S_IDLE;
      count   <= '0;
      op_q    <= '0;
      neg_a_q <= 1'b0;
      neg_b_q <= 1'b0;
      m       <= '0;
      p       <= '0;
      result  <= '0;
    end else if (flush) begin
      state <= S_IDLE;
    end else begin
      case (state)
        S_IDLE: if (capture) begin
          op_q    <= op;
          neg_a_q <= neg_a;
          neg_b_q <= neg_b;
          count   <= '0;
          m       <= is_div ? abs_b : abs_a;
          p       <= {{XLEN{1'b0}}, is_div ? abs_a : abs_b};
          if (special) begin
            result <= spec_val;
            state  <= S_DONE;
          end else begin
            state  <= S_RUN;
          end
        end
        S_RUN: begin
          p     <= op_q[2] ? div_nxt : mul_nxt;
          count <= count + 1'b1;
          if (count == CLAST) state <= S_FIX;
        end
        S_FIX: begin
          result <= fix_val;
          state  <= S_DONE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign busy  = (state == S_RUN) || (state == S_FIX);
  assign done  = (state == S_DONE);
  assign stall = capture || busy;

endmodule

// File: tb/tb_ex_muldiv.sv
// Self-checking bench for ex_muldiv: directed RV32M cases plus randomized ops
// against a 64-bit arithmetic reference model.
module tb_ex_muldiv;
  logic        clk = 1'b0, rstn = 1'b0, start = 1'b0, flush = 1'b0;
  logic [2:0]  op = '0;
  logic [31:0] rs1 = '0, rs2 = '0;
  logic        stall, busy, done;
  logic [31:0] result;

  int n_cmp = 0, n_err = 0;

  ex_muldiv #(.XLEN(32)) dut (
    .clk(clk), .rstn(rstn), .start(start), .op(op), .rs1(rs1), .rs2(rs2),
    .flush(flush), .stall(stall), .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_f(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, r;
    logic [63:0] u;
    sa = (o inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd6}) ? longint'($signed(a)) : longint'({32'b0, a});
    sb = (o inside {3'd0, 3'd1, 3'd4, 3'd6})       ? longint'($signed(b)) : longint'({32'b0, b});
    if (!o[2]) begin
      r = sa * sb;
      u = r;
      return (o == 3'd0) ? u[31:0] : u[63:32];
    end
    if (b == 32'd0) return o[1] ? a : 32'hFFFF_FFFF;
    r = o[1] ? (sa % sb) : (sa / sb);
    u = r;
    return u[31:0];
  endfunction

  function automatic int ref_lat(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    if (o[2] && (b == 0 || (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) return 1;
    return 34;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 20));
      4: return -32'($urandom_range(1, 20));
      default: return $urandom;
    endcase
  endfunction

  // Drives one op, scrambles the operands after capture, and waits for done.
  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input int lat, input string tag);
    int n, sc;
    bit seen;
    @(negedge clk);
    start = 1'b1; op = o; rs1 = a; rs2 = b;
    n = 0; sc = 0; seen = 1'b0;
    for (int k = 0; k < 100; k++) begin
      if (k > 0) begin
        @(negedge clk);
        rs1 = $urandom; rs2 = $urandom;
      end
      #1;
      if (stall) sc++;
      if (done) begin
        seen = 1'b1;
        n = k;
        break;
      end
    end
    start = 1'b0;
    if (!seen) chk({tag, ".timeout"}, 32'd0, 32'd1);
    else begin
      chk({tag, ".res"}, result, exp);
      chk({tag, ".lat"}, 32'(n), 32'(lat));
      chk({tag, ".stall"}, 32'(sc), 32'(lat));
    end
  endtask

  initial begin
    int dp;
    logic [2:0]  o;
    logic [31:0] a, b;

    #2;
    chk("rst.busy", {31'b0, busy}, 0);
    chk("rst.done", {31'b0, done}, 0);
    chk("rst.result", result, 0);
    chk("rst.stall", {31'b0, stall}, 0);
    @(negedge clk); rstn = 1'b1;

    run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 34, "mul7x-3");
    run_op(3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 34, "mulh");
    run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34, "mulhu");
    run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 34, "mulhsu");
    run_op(3'd4, -32'd7, 32'd2, 32'hFFFF_FFFD, 34, "div-7/2");
    run_op(3'd6, -32'd7, 32'd2, 32'hFFFF_FFFF, 34, "rem-7/2");
    run_op(3'd5, 32'd100, 32'd7, 32'd14, 34, "divu");
    run_op(3'd7, 32'd100, 32'd7, 32'd2, 34, "remu");
    run_op(3'd4, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, "div0");
    run_op(3'd7, 32'd5, 32'd0, 32'd5, 1, "remu0");
    run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, "divovf");
    run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1, "removf");

    // flush in the middle of a DIVU: result from the previous op must survive
    @(negedge clk);
    start = 1'b1; op = 3'd5; rs1 = 32'd100; rs2 = 32'd7;
    repeat (11) @(negedge clk);
    #1 chk("flush.busy_pre", {31'b0, busy}, 1);
    flush = 1'b1; start = 1'b0;
    @(negedge clk); #1;
    flush = 1'b0;
    chk("flush.stall", {31'b0, stall}, 0);
    chk("flush.busy", {31'b0, busy}, 0);
    chk("flush.result", result, 32'd0);
    dp = 0;
    repeat (40) begin @(negedge clk); #1; if (done) dp++; end
    chk("flush.nodone", 32'(dp), 0);
    run_op(3'd0, 32'd3, 32'd4, 32'd12, 34, "mul3x4");

    // flush and start together in IDLE: nothing starts
    @(negedge clk);
    start = 1'b1; flush = 1'b1; op = 3'd0; rs1 = 32'd5; rs2 = 32'd5;
    #1 chk("fs.stall", {31'b0, stall}, 0);
    @(negedge clk); #1;
    chk("fs.busy", {31'b0, busy}, 0);
    chk("fs.done", {31'b0, done}, 0);
    start = 1'b0; flush = 1'b0;

    // async reset mid-RUN
    @(negedge clk);
    start = 1'b1; op = 3'd5; rs1 = 32'd100; rs2 = 32'd7;
    repeat (5) @(negedge clk);
    #1 chk("arst.busy_pre", {31'b0, busy}, 1);
    rstn = 1'b0;
    #1;
    chk("arst.busy", {31'b0, busy}, 0);
    chk("arst.done", {31'b0, done}, 0);
    chk("arst.result", result, 0);
    start = 1'b0;
    @(negedge clk); rstn = 1'b1;

    run_op(3'd0, 32'd3, 32'd4, 32'd12, 34, "b2b.mul");
    run_op(3'd5, 32'd100, 32'd7, 32'd14, 34, "b2b.divu");

    for (int i = 0; i < 300; i++) begin
      o = 3'($urandom_range(0, 7));
      a = pick();
      b = pick();
      run_op(o, a, b, ref_f(o, a, b), ref_lat(o, a, b), $sformatf("rnd%0d.op%0d", i, o));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
